// File: rtl/iobus_pkg.sv
// Shared types and constants for the CPU-to-memory/device handshake bridge.
// Holds the FSM state encoding, the IO region prefix and the slot-field width.
package iobus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StDev,
    StResp
  } state_e;

  localparam logic [19:0] IO_PREFIX = 20'hFFFFF;
  localparam int unsigned SLOT_W    = 4;

endpackage

// File: rtl/iobus_addr_dec.sv
// Combinational address decoder: splits a CPU byte address into the IO-region
// flag, the device slot index, the in-slot offset and a slot-populated flag.
module iobus_addr_dec
  import iobus_pkg::*;
#(
  parameter int unsigned NDEV   = 4,
  parameter int unsigned DEV_AW = 12
) (
  input  logic [31:0]              addr_i,
  output logic                     is_io_o,
  output logic [SLOT_W-1:0]        slot_o,
  output logic [DEV_AW-SLOT_W-1:0] offset_o,
  output logic                     slot_valid_o
);

  assign is_io_o      = (addr_i[31:12] == IO_PREFIX);
  assign slot_o       = addr_i[DEV_AW-1 -: SLOT_W];
  assign offset_o     = addr_i[DEV_AW-SLOT_W-1:0];
  assign slot_valid_o = (32'(slot_o) < NDEV);

endmodule

// File: rtl/iobus_hs.sv
// Single-outstanding CPU bus bridge: routes each request to memory (one cycle)
// or to a memory-mapped device slot (ready handshake with timeout).
module iobus_hs
  import iobus_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned NDEV    = 4,
  parameter int unsigned DEV_AW  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic                     cpu_busy,
  output logic [31:0]              mem_addr,
  output logic [DW-1:0]            mem_wr_data,
  output logic                     mem_wr_e,
  input  logic [DW-1:0]            mem_rd_data,
  output logic [DEV_AW-SLOT_W-1:0] dv_addr,
  output logic [NDEV-1:0]          dv_sel,
  output logic [DW-1:0]            dv_wr_data,
  output logic                     dv_wr_e,
  output logic                     dv_rd_e,
  input  logic [NDEV*DW-1:0]       dv_rd_data,
  input  logic [NDEV-1:0]          dv_ready
);

  state_e                    state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic [DW-1:0]             wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [DEV_AW-SLOT_W-1:0]  offset_q, offset_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic                      dec_is_io;
  logic [SLOT_W-1:0]         dec_slot;
  logic [DEV_AW-SLOT_W-1:0]  dec_offset;
  logic                      dec_slot_valid;
  logic                      rdy_sel;
  logic [DW-1:0]             rd_sel;

  iobus_addr_dec #(
    .NDEV   (NDEV),
    .DEV_AW (DEV_AW)
  ) u_addr_dec (
    .addr_i       (cpu_addr),
    .is_io_o      (dec_is_io),
    .slot_o       (dec_slot),
    .offset_o     (dec_offset),
    .slot_valid_o (dec_slot_valid)
  );

  // Only the latched slot's ready and read data are ever looked at.
  always_comb begin
    rdy_sel = 1'b0;
    rd_sel  = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (slot_q == SLOT_W'(k)) begin
        rdy_sel = dv_ready[k];
        rd_sel  = dv_rd_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    slot_d   = slot_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          we_d     = cpu_we;
          slot_d   = dec_slot;
          offset_d = dec_offset;
          err_d    = 1'b0;
          if (!dec_is_io) begin
            state_d = StMem;
          end else if (dec_slot_valid) begin
            state_d = StDev;
            cnt_d   = '0;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      StMem: begin
        state_d = StResp;
        rdata_d = we_q ? '0 : mem_rd_data;
      end
      StDev: begin
        // Ready wins over a timeout landing in the same cycle.
        if (rdy_sel) begin
          state_d = StResp;
          rdata_d = we_q ? '0 : rd_sel;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      slot_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      slot_q   <= slot_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    mem_addr    = '1;
    mem_wr_data = '0;
    mem_wr_e    = 1'b0;
    dv_sel      = '0;
    dv_addr     = '1;
    dv_wr_data  = '0;
    dv_wr_e     = 1'b0;
    dv_rd_e     = 1'b0;
    if (state_q == StMem) begin
      mem_addr    = addr_q;
      mem_wr_data = wdata_q;
      mem_wr_e    = we_q;
    end
    if (state_q == StDev) begin
      for (int k = 0; k < NDEV; k++) begin
        dv_sel[k] = (slot_q == SLOT_W'(k));
      end
      dv_addr    = offset_q;
      dv_wr_data = wdata_q;
      dv_wr_e    = we_q;
      dv_rd_e    = ~we_q;
    end
  end

  assign cpu_ack   = (state_q == StResp);
  assign cpu_err   = (state_q == StResp) & err_q;
  assign cpu_busy  = (state_q != StIdle);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_iobus_hs.sv
// Self-checking bench for iobus_hs: directed vector table, multi-cycle corner
// sequences (held request, reset mid-access) and randomized transactions.
module tb_iobus_hs;

  localparam int DW      = 32;
  localparam int NDEV    = 4;
  localparam int DEV_AW  = 12;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr;
  logic [DW-1:0]     cpu_wdata, cpu_rdata;
  logic              cpu_ack, cpu_err, cpu_busy;
  logic [31:0]       mem_addr;
  logic [DW-1:0]     mem_wr_data, mem_rd_data;
  logic              mem_wr_e;
  logic [7:0]        dv_addr;
  logic [NDEV-1:0]   dv_sel, dv_ready;
  logic [DW-1:0]     dv_wr_data;
  logic              dv_wr_e, dv_rd_e;
  logic [NDEV*DW-1:0] dv_rd_data;
  logic [DW-1:0]     dvd [NDEV];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NDEV; k++) dv_rd_data[k*DW +: DW] = dvd[k];
  end

  iobus_hs #(
    .DW      (DW),
    .NDEV    (NDEV),
    .DEV_AW  (DEV_AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_err     (cpu_err),
    .cpu_busy    (cpu_busy),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_e    (mem_wr_e),
    .mem_rd_data (mem_rd_data),
    .dv_addr     (dv_addr),
    .dv_sel      (dv_sel),
    .dv_wr_data  (dv_wr_data),
    .dv_wr_e     (dv_wr_e),
    .dv_rd_e     (dv_rd_e),
    .dv_rd_data  (dv_rd_data),
    .dv_ready    (dv_ready)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memrd;
    int          waits;   // -1: selected device never signals ready
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic idle_state_ok();
    return !cpu_ack && !cpu_err && !cpu_busy && cpu_rdata == '0 && dv_sel == '0 &&
           dv_addr == '1 && !dv_wr_e && !dv_rd_e && dv_wr_data == '0 &&
           mem_addr == '1 && mem_wr_data == '0 && !mem_wr_e;
  endfunction

  // 1 when this cycle's bus outputs disagree with the access in flight.
  function automatic logic bad_cycle(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata);
    logic [NDEV-1:0] e;
    logic            bad;
    e = '0;
    for (int k = 0; k < NDEV; k++) if (k == int'(addr[11:8])) e[k] = 1'b1;
    bad = 1'b0;
    if (dv_sel != '0) begin
      if (dv_sel != e || dv_addr != addr[7:0] || dv_wr_data != wdata ||
          dv_wr_e != we || dv_rd_e != !we) bad = 1'b1;
    end else if (dv_addr != '1 || dv_wr_data != '0 || dv_wr_e || dv_rd_e) begin
      bad = 1'b1;
    end
    if (mem_addr != '1) begin
      if (mem_addr != addr || mem_wr_e != we || (we && mem_wr_data != wdata)) bad = 1'b1;
    end else if (mem_wr_data != '0 || mem_wr_e) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  // Expected outcome derived from the address map, wait count and timeout rule.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] memrd,
                       input int waits, output int lat, output logic err,
                       output logic [31:0] rdata, output int dev_c, output int mem_c);
    int slot;
    slot  = int'(addr[11:8]);
    dev_c = 0;
    mem_c = 0;
    if (addr[31:12] != 20'hFFFFF) begin
      lat = 2; err = 1'b0; rdata = we ? 32'h0 : memrd; mem_c = 1;
    end else if (slot >= NDEV) begin
      lat = 1; err = 1'b1; rdata = 32'h0;
    end else if (waits >= 0 && waits <= TIMEOUT) begin
      lat = 2 + waits; err = 1'b0; rdata = we ? 32'h0 : dvd[slot]; dev_c = lat - 1;
    end else begin
      lat = TIMEOUT + 2; err = 1'b1; rdata = 32'h0; dev_c = lat - 1;
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after the ack.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memrd, input int waits, output int lat,
                         output logic [31:0] rdata, output logic err, output int wr_c,
                         output int rd_c, output int mem_c, output int memwr_c,
                         output int dev_c, output int bad, output logic hold_ok);
    int d;
    int slot;
    d = 0; lat = -1; rdata = '0; err = 1'b0; hold_ok = 1'b0;
    wr_c = 0; rd_c = 0; mem_c = 0; memwr_c = 0; dev_c = 0; bad = 0;
    slot = int'(addr[11:8]);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_rd_data = memrd;
    dv_ready = NDEV'($urandom());
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (bad_cycle(we, addr, wdata)) bad++;
      if (dv_sel != '0) dev_c++;
      if (dv_wr_e) wr_c++;
      if (dv_rd_e) rd_c++;
      if (mem_addr != '1) mem_c++;
      if (mem_wr_e) memwr_c++;
      dv_ready = NDEV'($urandom());
      if (dv_sel != '0 && slot < NDEV) begin
        dv_ready[slot] = (d == waits);
        d++;
      end
      if (cpu_ack) begin
        lat = c; rdata = cpu_rdata; err = cpu_err;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      hold_ok = (cpu_rdata == rdata) && !cpu_ack && !cpu_busy && !bad_cycle(we, addr, wdata);
    end
  endtask

  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] memrd, input int waits,
                        input logic use_tab, input int t_lat, input logic t_err,
                        input logic [31:0] t_rdata);
    int lat, wr_c, rd_c, mem_c, memwr_c, dev_c, bad;
    int e_lat, e_dev, e_mem;
    logic [31:0] rdata, e_rdata;
    logic err, e_err, hold_ok;
    run_txn(we, addr, wdata, memrd, waits, lat, rdata, err, wr_c, rd_c, mem_c, memwr_c,
            dev_c, bad, hold_ok);
    model(we, addr, memrd, waits, e_lat, e_err, e_rdata, e_dev, e_mem);
    if (use_tab) begin
      e_lat = t_lat; e_err = t_err; e_rdata = t_rdata;
    end
    chk({name, " latency"}, 32'(lat), 32'(e_lat));
    chk({name, " err"}, 32'(err), 32'(e_err));
    chk({name, " rdata"}, rdata, e_rdata);
    chk({name, " rdata_hold/ack_pulse"}, 32'(hold_ok), 32'd1);
    chk({name, " bus_output_cycles_bad"}, 32'(bad), 32'd0);
    chk({name, " dv_wr_e_cycles"}, 32'(wr_c), we ? 32'(e_dev) : 32'd0);
    chk({name, " dv_rd_e_cycles"}, 32'(rd_c), we ? 32'd0 : 32'(e_dev));
    chk({name, " mem_cycles"}, 32'(mem_c), 32'(e_mem));
    chk({name, " mem_wr_e_cycles"}, 32'(memwr_c), we ? 32'(e_mem) : 32'd0);
  endtask

  initial begin
    vec_t tab[10];
    int   acks, wrs;
    logic [31:0] a;

    tab[0] = '{"mem_rd",      1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, -1, 2,  1'b0, 32'hDEAD_BEEF};
    tab[1] = '{"dev_wr_w3",   1'b1, 32'hFFFF_F104, 32'h0000_005A, 32'h0,         3, 5,  1'b0, 32'h0};
    tab[2] = '{"dev_timeout", 1'b0, 32'hFFFF_F200, 32'h0,        32'h0,         -1, 17, 1'b1, 32'h0};
    tab[3] = '{"unmapped7",   1'b0, 32'hFFFF_F700, 32'h0,        32'h0,         -1, 1,  1'b1, 32'h0};
    tab[4] = '{"dev_rd_w0",   1'b0, 32'hFFFF_F3FC, 32'h0,        32'h0,          0, 2,  1'b0, 32'h4444_4444};
    tab[5] = '{"dev_rd_w15",  1'b0, 32'hFFFF_F010, 32'h0,        32'h0,         15, 17, 1'b0, 32'h1111_1111};
    tab[6] = '{"dev_rd_w16",  1'b0, 32'hFFFF_F120, 32'h0,        32'h0,         16, 17, 1'b1, 32'h0};
    tab[7] = '{"mem_wr",      1'b1, 32'h0000_1234, 32'hCAFE_F00D, 32'h5555_5555, -1, 2,  1'b0, 32'h0};
    tab[8] = '{"mem_near_io", 1'b0, 32'hFFFF_EFFC, 32'h0,        32'h1234_5678, -1, 2,  1'b0, 32'h1234_5678};
    tab[9] = '{"unmapped15",  1'b1, 32'hFFFF_FF00, 32'h0000_0077, 32'h0,        -1, 1,  1'b1, 32'h0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rd_data = '0; dv_ready = '0;
    dvd[0] = 32'h1111_1111; dvd[1] = 32'h2222_2222; dvd[2] = 32'h3333_3333; dvd[3] = 32'h4444_4444;
    repeat (3) @(negedge clk);
    chk("reset_outputs_during_rst", 32'(idle_state_ok()), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_after_rst", 32'(idle_state_ok()), 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_txn(tab[i].name, tab[i].we, tab[i].addr, tab[i].wdata, tab[i].memrd, tab[i].waits,
             1'b1, tab[i].lat, tab[i].err, tab[i].rdata);
    end

    // Request held high: one access per idle sampling, no extra strobes.
    acks = 0; wrs = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0200; cpu_wdata = 32'hA5A5_0001;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (mem_wr_e) wrs++;
      if (c == 6) cpu_req = 1'b0;
    end
    chk("held_req acks", 32'(acks), 32'd2);
    chk("held_req mem_wr_e_cycles", 32'(wrs), 32'd2);
    @(negedge clk);
    chk("held_req back_idle", 32'(cpu_busy), 32'd0);

    // Reset in the middle of a device wait: access dropped, no ack.
    do_txn("pre_reset_rd", 1'b0, 32'h0000_0040, 32'h0, 32'h1357_9BDF, -1, 1'b0, 0, 1'b0, 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_F2A0; dv_ready = '0;
    acks = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      dv_ready = NDEV'($urandom()) & ~NDEV'(4);
      if (cpu_ack) acks++;
    end
    chk("mid_reset in_dev", 32'(dv_sel), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset outputs", 32'(idle_state_ok()), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("mid_reset no_ack", 32'(acks), 32'd0);
    do_txn("post_reset_dev", 1'b0, 32'hFFFF_F2A0, 32'h0, 32'h0, 15, 1'b0, 0, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NDEV; k++) dvd[k] = $urandom();
      a = $urandom();
      case ($urandom_range(0, 2))
        0: if (a[31:12] == 20'hFFFFF) a[12] = 1'b0;
        1: a = {20'hFFFFF, 4'($urandom_range(0, NDEV - 1)), 8'($urandom())};
        default: a = {20'hFFFFF, 12'($urandom())};
      endcase
      do_txn("random", 1'($urandom()), a, $urandom(), $urandom(),
             int'($urandom_range(0, 20)), 1'b0, 0, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iobus_hs.md
IOBUS_HS -- requirements
Module: iobus_hs

Interface
REQ-001 Parameter DW, 32, data width (CPU, memory, devices).
REQ-002 Parameter NDEV, 4, number of device slots (1..16).
REQ-003 Parameter DEV_AW, 12, device address width; slot index = addr[DEV_AW-1:DEV_AW-4], offset = addr[DEV_AW-5:0].
REQ-004 Parameter TIMEOUT, 15, max device wait cycles before error (1..255).
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, synchronous active-high reset.
- cpu_req, in, 1, access request, sampled in IDLE only.
- cpu_we, in, 1, 1 = write, 0 = read.
- cpu_addr, in, 32, byte address.
- cpu_wdata, in, DW, write data.
- cpu_rdata, out, DW, read data, valid with cpu_ack.
- cpu_ack, out, 1, one-cycle completion pulse.
- cpu_err, out, 1, error flag, valid with cpu_ack.
- cpu_busy, out, 1, high while an access is outstanding.
- mem_addr, out, 32, memory address.
- mem_wr_data, out, DW, memory write data.
- mem_wr_e, out, 1, memory write strobe.
- mem_rd_data, in, DW, memory read data, combinational from mem_addr.
- dv_addr, out, DEV_AW-4, device offset.
- dv_sel, out, NDEV, one-hot device select.
- dv_wr_data, out, DW, device write data.
- dv_wr_e, out, 1, device write strobe.
- dv_rd_e, out, 1, device read strobe.
- dv_rd_data, in, NDEV*DW, flattened per-slot read data; slot k at [k*DW +: DW].
- dv_ready, in, NDEV, per-slot completion.

Function
REQ-006 IO region: cpu_addr[31:12] == 20'hFFFFF; all other addresses are memory.
REQ-007 FSM states: IDLE, MEM, DEV, RESP.
REQ-008 Transitions:
- IDLE with cpu_req: latch addr, wdata, we; go to MEM (memory), DEV (mapped slot), or RESP with error (slot >= NDEV).
- MEM: always to RESP next cycle.
- DEV: to RESP on dv_ready[slot], or on timeout.
- RESP: to IDLE next cycle.
REQ-009 MEM, one cycle: mem_addr = latched addr; mem_wr_e = we; read captures mem_rd_data at end of cycle.
REQ-010 DEV outputs:
- dv_sel one-hot on the latched slot; dv_addr = latched offset.
- dv_wr_e = we; dv_rd_e = ~we; all held stable every DEV cycle.
- Read captures slot data in the cycle dv_ready[slot] is high.
REQ-011 Timeout: wait counter clears on DEV entry and increments each DEV cycle without ready; at count == TIMEOUT, go to RESP with cpu_err=1 and rdata 0. Ready in the same cycle as timeout completes the access as success.
REQ-012 Idle outputs: outside MEM, mem_addr = 32'hFFFFFFFF, mem_wr_data = 0, mem_wr_e = 0; outside DEV, dv_sel = 0, dv_addr = all-ones, strobes 0, dv_wr_data = 0.
REQ-013 RESP: cpu_ack = 1 for exactly one cycle. cpu_rdata holds its value until the next ack; it is 0 after writes and errors.
REQ-014 cpu_busy = (state != IDLE); cpu_req outside IDLE is ignored, never queued.
REQ-015 Latency, req-to-ack: memory 2 cycles; device 2+W cycles (W = wait cycles before ready); unmapped slot 1 cycle; timeout TIMEOUT+2 cycles.
REQ-016 dv_ready of unselected slots is ignored.

Reset
REQ-017 rst forces IDLE at the next edge, including mid-access. All outputs then go to their REQ-012 values; cpu_ack, cpu_err, cpu_busy = 0, cpu_rdata = 0, and the wait counter = 0.
REQ-018 An aborted access produces no ack.

Structure
REQ-019 Package iobus_pkg holds the state encoding, the IO_PREFIX constant 20'hFFFFF, and the slot-field width constant 4.
REQ-020 One combinational sub-module, iobus_addr_dec: address in; is_io, slot, offset, and slot_valid out.

Verification
REQ-021 Memory read: addr 0x00000010, mem_rd_data 0xDEADBEEF -> ack at cycle 2, rdata 0xDEADBEEF, err 0.
REQ-022 Device write: addr 0xFFFFF104, wdata 0x5A, dv_ready[1] after 3 waits -> dv_sel 4'b0010, dv_addr 0x04, dv_wr_e high 4 cycles, ack at cycle 5.
REQ-023 Timeout: read 0xFFFFF200, dv_ready 0 -> ack at cycle 17, err 1, rdata 0.
REQ-024 Unmapped: read 0xFFFFF700 with NDEV=4 -> ack at cycle 1, err 1, no strobes.
REQ-025 Reset during DEV wait -> no ack; all outputs at reset values; the next request completes normally.
REQ-026 cpu_req held high through busy -> exactly one access per IDLE sampling, no duplicate strobes.
